// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser (one channel, running status) feeding a polyphonic voice allocator.
// Optional sustain-pedal (CC64) handling is compiled in when MIDI_SUSTAIN_EN is defined.
module midi_voice_allocator #(
   parameter int unsigned VOICES  = 4,
   parameter int unsigned CHANNEL = 0,
   parameter int unsigned AGE_W   = 8
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic [7:0]                 midiByte,
   input  logic                       midiByteReady,
   output logic [7*VOICES-1:0]        voiceNote,
   output logic [7*VOICES-1:0]        voiceVelocity,
   output logic [VOICES-1:0]          voiceGate,
   output logic [VOICES-1:0]          voiceTrigger,
   output logic                       parseError
);
   localparam int unsigned      NOTE_W  = 7;
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
   localparam logic [3:0]       CHAN    = 4'(CHANNEL);

   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, EXEC} state_t;

   state_t              state_q, state_d;
   logic                ready_prev_q;
   logic [7:0]          byte_q;
   logic                byte_vld_q;
   logic                rs_skip_q, rs_skip_d;
   logic                rs_len1_q, rs_len1_d;
   logic                rs_off_q, rs_off_d;
   logic [NOTE_W-1:0]   d1_q, d1_d;
   logic [NOTE_W-1:0]   d2_q, d2_d;
   logic                parse_err_q, parse_err_d;
   logic [NOTE_W-1:0]   note_q [VOICES];
   logic [NOTE_W-1:0]   note_d [VOICES];
   logic [NOTE_W-1:0]   vel_q  [VOICES];
   logic [NOTE_W-1:0]   vel_d  [VOICES];
   logic [AGE_W-1:0]    age_q  [VOICES];
   logic [AGE_W-1:0]    age_d  [VOICES];
   logic [VOICES-1:0]   gate_q, gate_d;
   logic [VOICES-1:0]   trig_q, trig_d;
   logic [VOICES-1:0]   pick_oh, off_mask;
`ifdef MIDI_SUSTAIN_EN
   logic                rs_cc_q, rs_cc_d;
   logic                pedal_q, pedal_d;
   logic [VOICES-1:0]   sus_q, sus_d;
   logic                is_cc_c;
`endif

   logic accept_c, consume_c, exec_go_c;
   logic is_data_c, is_rt_c, is_sys_c, is_chan_c, is_note_c, is_len1_c;

   // New byte only on a 0->1 edge of the ready level; parser consumes it a cycle later
   assign accept_c  = midiByteReady & ~ready_prev_q;
   assign consume_c = byte_vld_q & (state_q != EXEC);

   assign is_data_c = ~byte_q[7];
   assign is_rt_c   = (byte_q[7:3] == 5'b11111);
   assign is_sys_c  = (byte_q[7:3] == 5'b11110);
   assign is_chan_c = byte_q[7] & (byte_q[7:4] != 4'hF);
   assign is_note_c = (byte_q[7:5] == 3'b100) & (byte_q[3:0] == CHAN);
   assign is_len1_c = (byte_q[7:5] == 3'b110);
`ifdef MIDI_SUSTAIN_EN
   assign is_cc_c   = (byte_q[7:4] == 4'hB) & (byte_q[3:0] == CHAN);
   assign exec_go_c = ~rs_skip_q & ~(rs_cc_q & (d1_q != 7'd64));
`else
   assign exec_go_c = ~rs_skip_q;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (!resetN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (state_q == EXEC) begin
         state_d = WAIT_D1;
      end else if (consume_c && !is_rt_c) begin
         if (is_sys_c) begin
            state_d = IDLE;
         end else if (is_chan_c) begin
            state_d = WAIT_D1;
         end else if (is_data_c) begin
            case (state_q)
               WAIT_D1: state_d = (rs_skip_q && rs_len1_q) ? WAIT_D1 : WAIT_D2;
               WAIT_D2: state_d = exec_go_c ? EXEC : WAIT_D1;
               default: state_d = state_q;
            endcase
         end
      end
   end

   // Voice selection: same-note match, else lowest free, else oldest (lowest index on ties)
   always_comb begin
      logic [VOICES-1:0] match_oh, free_oh, steal_oh;
      logic [AGE_W-1:0]  best_age;
      logic              found_m, found_f;
      match_oh = '0;
      free_oh  = '0;
      steal_oh = '0;
      off_mask = '0;
      best_age = '0;
      found_m  = 1'b0;
      found_f  = 1'b0;
      for (int i = 0; i < VOICES; i++) begin
         if (gate_q[i] && (note_q[i] == d1_q)) begin
            off_mask[i] = 1'b1;
            if (!found_m) begin
               match_oh[i] = 1'b1;
               found_m     = 1'b1;
            end
         end
         if (!gate_q[i] && !found_f) begin
            free_oh[i] = 1'b1;
            found_f    = 1'b1;
         end
         if ((i == 0) || (age_q[i] > best_age)) begin
            best_age    = age_q[i];
            steal_oh    = '0;
            steal_oh[i] = 1'b1;
         end
      end
      if (found_m)      pick_oh = match_oh;
      else if (found_f) pick_oh = free_oh;
      else              pick_oh = steal_oh;
   end

   // Output / datapath logic: running status, data latches and voice updates in EXEC
   always_comb begin
      rs_skip_d   = rs_skip_q;
      rs_len1_d   = rs_len1_q;
      rs_off_d    = rs_off_q;
      d1_d        = d1_q;
      d2_d        = d2_q;
      parse_err_d = 1'b0;
      trig_d      = '0;
      note_d      = note_q;
      vel_d       = vel_q;
      age_d       = age_q;
      gate_d      = gate_q;
`ifdef MIDI_SUSTAIN_EN
      rs_cc_d     = rs_cc_q;
      pedal_d     = pedal_q;
      sus_d       = sus_q;
`endif
      if (consume_c && !is_rt_c) begin
         if (is_sys_c) begin
            rs_skip_d = 1'b0;
            rs_len1_d = 1'b0;
            rs_off_d  = 1'b0;
`ifdef MIDI_SUSTAIN_EN
            rs_cc_d   = 1'b0;
`endif
         end else if (is_chan_c) begin
`ifdef MIDI_SUSTAIN_EN
            rs_skip_d = ~(is_note_c | is_cc_c);
            rs_cc_d   = is_cc_c;
`else
            rs_skip_d = ~is_note_c;
`endif
            rs_len1_d = is_len1_c;
            rs_off_d  = ~byte_q[4];
         end else begin
            case (state_q)
               IDLE:    parse_err_d = 1'b1;
               WAIT_D1: d1_d = byte_q[6:0];
               WAIT_D2: d2_d = byte_q[6:0];
               default: ;
            endcase
         end
      end

      if (state_q == EXEC) begin
`ifdef MIDI_SUSTAIN_EN
         if (rs_cc_q) begin
            pedal_d = d2_q[6];
            if (!d2_q[6]) begin
               gate_d = gate_q & ~sus_q;
               sus_d  = '0;
            end
         end else
`endif
         if (!rs_off_q && (d2_q != '0)) begin
            for (int i = 0; i < VOICES; i++) begin
               if (pick_oh[i]) begin
                  note_d[i] = d1_q;
                  vel_d[i]  = d2_q;
                  gate_d[i] = 1'b1;
                  trig_d[i] = 1'b1;
                  age_d[i]  = '0;
`ifdef MIDI_SUSTAIN_EN
                  sus_d[i]  = 1'b0;
`endif
               end else if (age_q[i] != AGE_MAX) begin
                  age_d[i] = age_q[i] + AGE_W'(1);
               end
            end
         end else begin
`ifdef MIDI_SUSTAIN_EN
            if (pedal_q) sus_d  = sus_q | off_mask;
            else         gate_d = gate_q & ~off_mask;
`else
            gate_d = gate_q & ~off_mask;
`endif
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (!resetN) begin
         ready_prev_q <= 1'b0;
         byte_q       <= '0;
         byte_vld_q   <= 1'b0;
         rs_skip_q    <= 1'b0;
         rs_len1_q    <= 1'b0;
         rs_off_q     <= 1'b0;
         d1_q         <= '0;
         d2_q         <= '0;
         parse_err_q  <= 1'b0;
         gate_q       <= '0;
         trig_q       <= '0;
         for (int i = 0; i < VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
            age_q[i]  <= AGE_MAX;
         end
`ifdef MIDI_SUSTAIN_EN
         rs_cc_q      <= 1'b0;
         pedal_q      <= 1'b0;
         sus_q        <= '0;
`endif
      end else begin
         ready_prev_q <= midiByteReady;
         if (accept_c) byte_q <= midiByte;
         byte_vld_q   <= accept_c | (byte_vld_q & ~consume_c);
         rs_skip_q    <= rs_skip_d;
         rs_len1_q    <= rs_len1_d;
         rs_off_q     <= rs_off_d;
         d1_q         <= d1_d;
         d2_q         <= d2_d;
         parse_err_q  <= parse_err_d;
         gate_q       <= gate_d;
         trig_q       <= trig_d;
         note_q       <= note_d;
         vel_q        <= vel_d;
         age_q        <= age_d;
`ifdef MIDI_SUSTAIN_EN
         rs_cc_q      <= rs_cc_d;
         pedal_q      <= pedal_d;
         sus_q        <= sus_d;
`endif
      end
   end

   for (genvar g = 0; g < VOICES; g++) begin : g_pack
      assign voiceNote[NOTE_W*g +: NOTE_W]     = note_q[g];
      assign voiceVelocity[NOTE_W*g +: NOTE_W] = vel_q[g];
   end

   assign voiceGate    = gate_q;
   assign voiceTrigger = trig_q;
   assign parseError   = parse_err_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomized bench for midi_voice_allocator: message-level reference model with a per-cycle
// compare process, plus directed sequences whose results are pinned with literal values.
module tb_midi_voice_allocator;
   localparam int VOICES  = 4;
   localparam int CHANNEL = 0;
   localparam int AGE_W   = 8;
   localparam int AGE_MAX = (1 << AGE_W) - 1;

   localparam int RS_NONE = 0, RS_ON = 1, RS_OFF = 2, RS_SKIP1 = 3, RS_SKIP2 = 4, RS_CC = 5;
   localparam int EV_RESET = 0, EV_PERR = 1, EV_ON = 2, EV_OFF = 3, EV_PEDAL = 4;

   logic                  clock;
   logic                  resetN;
   logic [7:0]            midiByte;
   logic                  midiByteReady;
   logic [7*VOICES-1:0]   voiceNote;
   logic [7*VOICES-1:0]   voiceVelocity;
   logic [VOICES-1:0]     voiceGate;
   logic [VOICES-1:0]     voiceTrigger;
   logic                  parseError;

   midi_voice_allocator #(.VOICES(VOICES), .CHANNEL(CHANNEL), .AGE_W(AGE_W)) dut (
      .clock(clock), .resetN(resetN), .midiByte(midiByte), .midiByteReady(midiByteReady),
      .voiceNote(voiceNote), .voiceVelocity(voiceVelocity), .voiceGate(voiceGate),
      .voiceTrigger(voiceTrigger), .parseError(parseError)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int eff;
      int kind;
      int note;
      int vel;
   } ev_t;

   ev_t evq[$];
   int  n_cmp = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;
   int  last_k = 0;

   // Reference model: message parser state and voice pool
   int     m_rs = RS_NONE;
   int     dq[$];
   int     m_note [VOICES];
   int     m_vel  [VOICES];
   bit     m_gate [VOICES];
   bit     m_sus  [VOICES];
   longint m_stamp[VOICES];
   longint m_n;
   bit     m_pedal;
   logic [VOICES-1:0] exp_trig;
   bit     exp_perr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int age_of(input int i);
      longint d = m_n - m_stamp[i];
      return (d > AGE_MAX) ? AGE_MAX : int'(d);
   endfunction

   // Parse one accepted byte (accept edge k) into queued voice events
   task automatic model_byte(input logic [7:0] b, input int k);
      int need;
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_rs = RS_NONE;
         dq.delete();
         return;
      end
      if (b >= 8'h80) begin
         dq.delete();
         if (int'(b[3:0]) == CHANNEL && b[7:4] == 4'h9)      m_rs = RS_ON;
         else if (int'(b[3:0]) == CHANNEL && b[7:4] == 4'h8) m_rs = RS_OFF;
`ifdef MIDI_SUSTAIN_EN
         else if (int'(b[3:0]) == CHANNEL && b[7:4] == 4'hB) m_rs = RS_CC;
`endif
         else if (b[7:4] == 4'hC || b[7:4] == 4'hD)          m_rs = RS_SKIP1;
         else                                                m_rs = RS_SKIP2;
         return;
      end
      if (m_rs == RS_NONE) begin
         evq.push_back('{k + 1, EV_PERR, 0, 0});
         return;
      end
      dq.push_back(int'(b));
      need = (m_rs == RS_SKIP1) ? 1 : 2;
      if (dq.size() == need) begin
         if (m_rs == RS_ON && dq[1] != 0)          evq.push_back('{k + 2, EV_ON, dq[0], dq[1]});
         else if (m_rs == RS_ON || m_rs == RS_OFF) evq.push_back('{k + 2, EV_OFF, dq[0], dq[1]});
         else if (m_rs == RS_CC && dq[0] == 64)    evq.push_back('{k + 2, EV_PEDAL, dq[0], dq[1]});
         dq.delete();
      end
   endtask

   task automatic apply(input ev_t e);
      int pick, best;
      case (e.kind)
         EV_RESET: begin
            for (int i = 0; i < VOICES; i++) begin
               m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_sus[i] = 0;
               m_stamp[i] = -1000000;
            end
            m_n = 0; m_pedal = 0; chk_en = 1'b1;
         end
         EV_PERR: exp_perr = 1'b1;
         EV_ON: begin
            pick = -1;
            for (int i = 0; i < VOICES; i++)
               if (pick < 0 && m_gate[i] && m_note[i] == e.note) pick = i;
            for (int i = 0; i < VOICES; i++)
               if (pick < 0 && !m_gate[i]) pick = i;
            if (pick < 0) begin
               best = -1;
               for (int i = 0; i < VOICES; i++)
                  if (age_of(i) > best) begin best = age_of(i); pick = i; end
            end
            m_n++;
            m_stamp[pick] = m_n;
            m_note[pick] = e.note; m_vel[pick] = e.vel; m_gate[pick] = 1; m_sus[pick] = 0;
            exp_trig[pick] = 1'b1;
         end
         EV_OFF: begin
            for (int i = 0; i < VOICES; i++)
               if (m_gate[i] && m_note[i] == e.note) begin
                  if (m_pedal) m_sus[i] = 1;
                  else         m_gate[i] = 0;
               end
         end
         default: begin
            if (e.vel >= 64) m_pedal = 1;
            else begin
               m_pedal = 0;
               for (int i = 0; i < VOICES; i++)
                  if (m_sus[i]) begin m_gate[i] = 0; m_sus[i] = 0; end
            end
         end
      endcase
   endtask

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      logic [7*VOICES-1:0] en, ev;
      logic [VOICES-1:0]   eg;
      exp_trig = '0;
      exp_perr = 1'b0;
      while (evq.size() > 0 && evq[0].eff <= cyc) apply(evq.pop_front());
      if (chk_en) begin
         for (int i = 0; i < VOICES; i++) begin
            en[7*i +: 7] = 7'(m_note[i]);
            ev[7*i +: 7] = 7'(m_vel[i]);
            eg[i]        = m_gate[i];
         end
         chk("note",    64'(voiceNote),     64'(en));
         chk("vel",     64'(voiceVelocity), 64'(ev));
         chk("gate",    64'(voiceGate),     64'(eg));
         chk("trigger", 64'(voiceTrigger),  64'(exp_trig));
         chk("perr",    64'(parseError),    64'(exp_perr));
      end
   end

   // Called at a negedge: present byte, hold level, then drop it
   task automatic send(input logic [7:0] b, input int hold, input int gap);
      midiByte      = b;
      midiByteReady = 1'b1;
      last_k        = cyc + 1;
      model_byte(b, last_k);
      repeat (hold) @(negedge clock);
      midiByteReady = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send(a, 1, 1); send(b, 1, 1); send(c, 1, 1);
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      evq.push_back('{cyc + 1, EV_RESET, 0, 0});
      m_rs = RS_NONE;
      dq.delete();
      @(negedge clock);
      resetN = 1'b1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   task automatic idle(); repeat (4) @(negedge clock); endtask

   initial begin
      logic [7:0] b;
      int r;
      resetN = 1'b0; midiByte = '0; midiByteReady = 1'b0;
      @(negedge clock);
      do_reset();
      chk("reset_gate", 64'(voiceGate), 64'(0));
      chk("reset_note", 64'(voiceNote), 64'(0));

      // Basic note on with latency and one-cycle trigger
      send3(8'h90, 8'h3C, 8'h40);
      wait_cyc(last_k + 2);
      chk("t1_trig", 64'(voiceTrigger), 64'(4'b0001));
      @(negedge clock);
      chk("t1_trig_off", 64'(voiceTrigger), 64'(0));
      chk("t1_note0", 64'(voiceNote[6:0]), 64'(60));
      chk("t1_vel0", 64'(voiceVelocity[6:0]), 64'(64));
      chk("t1_gate", 64'(voiceGate), 64'(4'b0001));
      chk("t1_model_note0", 64'(m_note[0]), 64'(60));

      // Running status note on, then note off by zero velocity
      send(8'h40, 1, 1); send(8'h50, 1, 1); idle();
      chk("t2_note1", 64'(voiceNote[13:7]), 64'(64));
      chk("t2_vel1", 64'(voiceVelocity[13:7]), 64'(80));
      send(8'h3C, 1, 1); send(8'h00, 1, 1); idle();
      chk("t2_gate", 64'(voiceGate), 64'(4'b0010));
      chk("t2_note0_kept", 64'(voiceNote[6:0]), 64'(60));

      // Oldest-voice stealing
      do_reset();
      send3(8'h90, 8'h3C, 8'h40); send(8'h3E, 1, 1); send(8'h40, 1, 1);
      send(8'h40, 1, 1); send(8'h40, 1, 1); send(8'h41, 1, 1); send(8'h40, 1, 1);
      send(8'h43, 1, 1); send(8'h40, 1, 1);
      wait_cyc(last_k + 2);
      chk("t3_trig", 64'(voiceTrigger), 64'(4'b0001));
      idle();
      chk("t3_note0", 64'(voiceNote[6:0]), 64'(67));
      chk("t3_note1", 64'(voiceNote[13:7]), 64'(62));
      chk("t3_note2", 64'(voiceNote[20:14]), 64'(64));
      chk("t3_note3", 64'(voiceNote[27:21]), 64'(65));
      chk("t3_model_pick", 64'(m_note[0]), 64'(67));

      // Channel filter, real-time passthrough, data without status
      do_reset();
      send3(8'h91, 8'h3C, 8'h40); idle();
      chk("t4_other_chan", 64'(voiceGate), 64'(0));
      send(8'h90, 1, 1); send3(8'hF8, 8'h3C, 8'h40); idle();
      chk("t4_realtime", 64'(voiceGate), 64'(4'b0001));
      do_reset();
      send(8'h3C, 1, 1);
      chk("t4_perr", 64'(parseError), 64'(1));
      @(negedge clock);
      chk("t4_perr_off", 64'(parseError), 64'(0));

      // Long ready level accepted once
      do_reset();
      send(8'h90, 1, 1); send(8'h3C, 1, 1); send(8'h40, 1000, 1); send(8'h41, 1, 1); idle();
      chk("t5_single_accept", 64'(voiceGate), 64'(4'b0001));

      // Reset mid-message clears running status
      do_reset();
      send(8'h90, 1, 1);
      do_reset();
      send(8'h3C, 1, 1);
      chk("t6_perr", 64'(parseError), 64'(1));
      send(8'h40, 1, 1); idle();
      chk("t6_gate", 64'(voiceGate), 64'(0));

`ifdef MIDI_SUSTAIN_EN
      do_reset();
      send3(8'h90, 8'h3C, 8'h40); send3(8'hB0, 8'h40, 8'h7F); send3(8'h80, 8'h3C, 8'h40); idle();
      chk("sus_hold", 64'(voiceGate), 64'(4'b0001));
      send3(8'hB0, 8'h40, 8'h00); idle();
      chk("sus_release", 64'(voiceGate), 64'(0));
`endif

      // Randomized byte stream
      do_reset();
      for (int n = 0; n < 500; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 12)      b = 8'h90;
         else if (r < 16) b = 8'h80;
         else if (r < 19) b = 8'h91;
         else if (r < 21) b = 8'hC0;
         else if (r < 23) b = 8'hB0;
         else if (r < 25) b = 8'hE0;
         else if (r < 27) b = 8'hF8;
         else if (r < 28) b = 8'hF0;
         else if (r < 50) b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
         else             b = 8'(60 + $urandom_range(0, 9));
         send(b, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
         if ($urandom_range(0, 99) == 0) begin
            repeat (3) @(negedge clock);
            do_reset();
         end
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
